// File: rtl/al_is_dispatch_if.sv
// Bundle of rename-side and issue-side signals around the allocation-to-issue dispatch buffer.
// The master side drives groups and issue backpressure; the slave side is the dispatch buffer.
interface al_is_dispatch_if #(
  parameter int INST_WIDTH = 56,
  parameter int INST_PORT  = 4,
  parameter int BRN_WIDTH  = 7,
  parameter int PTR_BITS   = 2,
  parameter int CNT_WIDTH  = 16
);
  logic [INST_PORT*INST_WIDTH-1:0] grp_frm_ren;
  logic                            grp_vld_frm_ren;
  logic                            lop_sta_frm_ren;
  logic                            rdy_to_ren;
  logic [INST_PORT*INST_WIDTH-1:0] inst_to_is;
  logic                            lop_sta_to_is;
  logic                            ful_frm_is;
  logic [BRN_WIDTH-1:0]            fls_frm_rob;
  logic [PTR_BITS:0]               buf_cnt;
  logic [CNT_WIDTH-1:0]            stl_cnt;

  modport master (
    output grp_frm_ren, grp_vld_frm_ren, lop_sta_frm_ren, ful_frm_is, fls_frm_rob,
    input  rdy_to_ren, inst_to_is, lop_sta_to_is, buf_cnt, stl_cnt
  );

  modport slave (
    input  grp_frm_ren, grp_vld_frm_ren, lop_sta_frm_ren, ful_frm_is, fls_frm_rob,
    output rdy_to_ren, inst_to_is, lop_sta_to_is, buf_cnt, stl_cnt
  );
endinterface

// File: rtl/al_is_dispatch.sv
// Dispatch buffer between rename and issue: queues 4-wide groups, presents each exactly once,
// honours issue-queue full, squashes on ROB flush and counts stalled cycles.
module al_is_dispatch #(
  parameter int INST_WIDTH   = 56,
  parameter int INST_PORT    = 4,
  parameter int BIT_INST_VLD = 55,
  parameter int BRN_WIDTH    = 7,
  parameter int BUF_DEPTH    = 4,
  parameter int PTR_BITS     = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  al_is_dispatch_if.slave bus
);

  localparam int GRP_W = INST_PORT * INST_WIDTH;
  localparam int ENT_W = GRP_W + 1;
  localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTV, STAL, FLSH} state_t;

  state_t               state_reg, state_next;
  logic [PTR_BITS-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_BITS:0]    buf_cnt_reg, buf_cnt_next;
  logic [CNT_WIDTH-1:0] stl_cnt_reg;
  logic [GRP_W-1:0]     inst_reg;
  logic                 lop_sta_reg;
  logic [ENT_W-1:0]     buf_mem [BUF_DEPTH];

  logic [INST_PORT-1:0] slot_vld;
  logic                 flush;
  logic                 grp_any;
  logic                 rdy;
  logic                 push;
  logic                 pop;
  logic                 stall;

  for (genvar gi = 0; gi < INST_PORT; gi++) begin : g_slot_vld
    assign slot_vld[gi] = bus.grp_frm_ren[gi*INST_WIDTH + BIT_INST_VLD];
  end

  assign flush   = bus.fls_frm_rob[BRN_WIDTH-1];
  assign grp_any = |slot_vld;

  // Ready depends on registered state only, so issue backpressure never reaches rename combinationally.
  always_comb begin
    rdy   = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    stall = 1'b0;
    rdy   = (buf_cnt_reg < DEPTH_CNT) && (state_reg != FLSH);
    push  = bus.grp_vld_frm_ren && rdy && grp_any && !flush;
    pop   = (buf_cnt_reg != '0) && !bus.ful_frm_is && !flush && (state_reg != FLSH);
    stall = (buf_cnt_reg != '0) && bus.ful_frm_is && !flush;
  end

  always_comb begin
    buf_cnt_next = buf_cnt_reg;
    if (push && !pop) begin
      buf_cnt_next = buf_cnt_reg + 1'b1;
    end else if (!push && pop) begin
      buf_cnt_next = buf_cnt_reg - 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = FLSH;
    end else begin
      case (state_reg)
        IDLE: if (push) state_next = ACTV;
        ACTV: begin
          if (bus.ful_frm_is && (buf_cnt_reg != '0)) begin
            state_next = STAL;
          end else if (buf_cnt_next == '0) begin
            state_next = IDLE;
          end
        end
        STAL: if (!bus.ful_frm_is) state_next = ACTV;
        FLSH: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Storage array carries no reset so it maps onto plain RAM; only pointers track validity.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wr_ptr_reg] <= {bus.lop_sta_frm_ren, bus.grp_frm_ren};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      buf_cnt_reg <= '0;
      inst_reg    <= '0;
      lop_sta_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        wr_ptr_reg  <= '0;
        rd_ptr_reg  <= '0;
        buf_cnt_reg <= '0;
        inst_reg    <= '0;
        lop_sta_reg <= 1'b0;
      end else begin
        buf_cnt_reg <= buf_cnt_next;
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        // The issue queue latches any valid slot, so the output is zeroed whenever nothing pops.
        if (pop) begin
          rd_ptr_reg  <= rd_ptr_reg + 1'b1;
          inst_reg    <= buf_mem[rd_ptr_reg][GRP_W-1:0];
          lop_sta_reg <= buf_mem[rd_ptr_reg][GRP_W];
        end else begin
          inst_reg    <= '0;
          lop_sta_reg <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stl_cnt_reg <= '0;
    end else if (stall && (stl_cnt_reg != '1)) begin
      stl_cnt_reg <= stl_cnt_reg + 1'b1;
    end
  end

  assign bus.rdy_to_ren    = rdy;
  assign bus.inst_to_is    = inst_reg;
  assign bus.lop_sta_to_is = lop_sta_reg;
  assign bus.buf_cnt       = buf_cnt_reg;
  assign bus.stl_cnt       = stl_cnt_reg;

endmodule

// File: tb/tb_al_is_dispatch.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_al_is_dispatch;

  localparam int GW = 224;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  al_is_dispatch_if #(.CNT_WIDTH(16)) bus ();
  al_is_dispatch_if #(.CNT_WIDTH(4))  bus4 ();

  assign bus4.grp_frm_ren     = bus.grp_frm_ren;
  assign bus4.grp_vld_frm_ren = bus.grp_vld_frm_ren;
  assign bus4.lop_sta_frm_ren = bus.lop_sta_frm_ren;
  assign bus4.ful_frm_is      = bus.ful_frm_is;
  assign bus4.fls_frm_rob     = bus.fls_frm_rob;

  al_is_dispatch #(.CNT_WIDTH(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  al_is_dispatch #(.CNT_WIDTH(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: ordered list of {lop_sta, group}, stall total, post-flush bubble flag.
  logic [GW:0] q[$];
  int          stl = 0;
  bit          bubble = 0;

  task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [GW-1:0] make_grp(input logic [3:0] mask);
    logic [GW-1:0] g;
    logic [63:0]   r;
    g = '0;
    for (int k = 0; k < 4; k++) begin
      r = {$urandom(), $urandom()};
      r[55] = mask[k];
      g[k*56 +: 56] = r[55:0];
    end
    return g;
  endfunction

  task automatic step(input logic vld, input logic [GW-1:0] g, input logic lop,
                      input logic ful, input logic [6:0] fls);
    bit rdy_e, anyv, push_e, pop_e, flush;
    logic [GW:0] exp_out;
    int sat16, sat4;
    @(negedge clk);
    bus.grp_vld_frm_ren = vld;
    bus.grp_frm_ren     = g;
    bus.lop_sta_frm_ren = lop;
    bus.ful_frm_is      = ful;
    bus.fls_frm_rob     = fls;
    #1;
    flush = fls[6];
    rdy_e = (q.size() < 4) && !bubble;
    chk("rdy_to_ren", GW'(bus.rdy_to_ren), GW'(rdy_e));
    anyv = 1'b0;
    for (int k = 0; k < 4; k++) anyv |= g[k*56 + 55];
    push_e  = vld && rdy_e && anyv && !flush;
    pop_e   = (q.size() != 0) && !ful && !flush && !bubble;
    exp_out = pop_e ? q[0] : '0;
    if ((q.size() != 0) && ful && !flush) stl++;
    if (flush) begin
      q.delete();
      bubble = 1;
    end else begin
      bubble = 0;
      if (pop_e) void'(q.pop_front());
      if (push_e) q.push_back({lop, g});
    end
    @(posedge clk);
    #1;
    sat16 = (stl > 65535) ? 65535 : stl;
    sat4  = (stl > 15) ? 15 : stl;
    chk("inst_to_is", bus.inst_to_is, exp_out[GW-1:0]);
    chk("lop_sta_to_is", GW'(bus.lop_sta_to_is), GW'(exp_out[GW]));
    chk("buf_cnt", GW'(bus.buf_cnt), GW'(q.size()));
    chk("stl_cnt", GW'(bus.stl_cnt), GW'(sat16));
    chk("stl_cnt_w4", GW'(bus4.stl_cnt), GW'(sat4));
  endtask

  task automatic idle(input int n, input logic ful);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, ful, 7'h00);
  endtask

  initial begin
    logic [GW-1:0] g;
    logic [55:0]   s0;
    logic [3:0]    mask;
    bus.grp_frm_ren = '0;
    bus.grp_vld_frm_ren = 1'b0;
    bus.lop_sta_frm_ren = 1'b0;
    bus.ful_frm_is = 1'b0;
    bus.fls_frm_rob = '0;

    // Reset state
    #3;
    chk("rst_inst", bus.inst_to_is, '0);
    chk("rst_buf_cnt", GW'(bus.buf_cnt), '0);
    chk("rst_stl_cnt", GW'(bus.stl_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", GW'(bus.rdy_to_ren), GW'(1));

    // Latency: single group out one edge after it is stored, then zero
    s0 = 56'h80_0000_0000_0001;
    g = make_grp(4'hF);
    g[55:0] = s0;
    step(1'b1, g, 1'b1, 1'b0, 7'h00);
    idle(3, 1'b0);

    // Backpressure: fill, hold off, saturate narrow counter, then drain in order
    for (int i = 0; i < 5; i++) step(1'b1, make_grp(4'(i + 1)), i[0], 1'b1, 7'h00);
    idle(20, 1'b1);
    idle(6, 1'b0);

    // Flush with a push offered, then the bubble cycle, then recovery
    for (int i = 0; i < 3; i++) step(1'b1, make_grp(4'hF), 1'b0, 1'b1, 7'h00);
    step(1'b1, make_grp(4'hF), 1'b1, 1'b0, 7'h45);
    step(1'b1, make_grp(4'hF), 1'b0, 1'b0, 7'h00);
    step(1'b1, make_grp(4'h3), 1'b0, 1'b0, 7'h00);
    idle(3, 1'b0);

    // Group with no valid slot is dropped
    step(1'b1, make_grp(4'h0), 1'b1, 1'b0, 7'h00);
    idle(2, 1'b0);

    // Random traffic with backpressure, flushes and empty groups
    for (int i = 0; i < 120; i++) begin
      mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom());
      step(($urandom_range(0, 9) < 7), make_grp(mask), 1'($urandom()),
           ($urandom_range(0, 9) < 4),
           {($urandom_range(0, 19) == 0), 6'($urandom())});
    end

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) step(1'b1, make_grp(4'hF), 1'b1, 1'b1, 7'h00);
    bus.grp_vld_frm_ren = 1'b0;
    bus.ful_frm_is = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_inst", bus.inst_to_is, '0);
    chk("mid_rst_buf_cnt", GW'(bus.buf_cnt), '0);
    chk("mid_rst_stl_cnt", GW'(bus.stl_cnt), '0);
    q.delete();
    stl = 0;
    bubble = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rdy", GW'(bus.rdy_to_ren), GW'(1));
    for (int i = 0; i < 4; i++) step(1'b1, make_grp(4'hF), 1'b0, 1'b0, 7'h00);
    idle(3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
